// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU responder: opcodes, FSM states, opcode width.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'b00,
    XOR = 2'b01,
    MUL = 2'b10,
    AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_BUSY = 2'b01,
    DONE     = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_op_responder_if.sv
// Request/response bus of the ALU responder. Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_op_responder_if #(
  parameter int unsigned WIDTH = 8
);
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  alu_op_e            in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  alu_op_e            out_op;
  logic [2*WIDTH-1:0] out_result;
`ifdef ALU_FLAGS_EN
  logic               out_zero;
  logic               out_carry;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_result, out_zero, out_carry
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_result, out_zero, out_carry
  );
`else
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_result
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_result
  );
`endif

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one bit of b per cycle, always WIDTH cycles.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  assign acc_d   = acc_q + (b_q[0] ? a_q : '0);
  // done and product are valid in the last iteration cycle; the owner captures on that edge.
  assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product = acc_d;
  assign busy    = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= {{WIDTH{1'b0}}, a};
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      if (done) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_op_responder.sv
// Sequential ALU (ADD/XOR/MUL/AND) with valid/ready request and response channels.
// Optional registered zero/carry flags are enabled by defining ALU_FLAGS_EN.
module alu_op_responder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  alu_op_responder_if.slave bus
);

  alu_state_e         state_q;
  logic               out_valid_q;
  alu_op_e            out_op_q;
  logic [2*WIDTH-1:0] out_result_q;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] alu_result;
  logic [WIDTH:0]     sum;

  // out_ready feeds in_ready combinationally so a consumed result can be replaced with no bubble.
  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.in_op == MUL);

  assign bus.out_valid  = out_valid_q;
  assign bus.out_op     = out_op_q;
  assign bus.out_result = out_result_q;

  assign sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};

  always_comb begin
    alu_result = '0;
    unique case (bus.in_op)
      ADD:     alu_result = {{(WIDTH - 1){1'b0}}, sum};
      XOR:     alu_result = {{WIDTH{1'b0}}, bus.in_a ^ bus.in_b};
      AND:     alu_result = {{WIDTH{1'b0}}, bus.in_a & bus.in_b};
      default: alu_result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic out_zero_q;
  logic out_carry_q;
  logic alu_carry;
  logic mul_carry;

  assign alu_carry     = (bus.in_op == ADD) && sum[WIDTH];
  assign mul_carry     = |mul_product[2*WIDTH-1:WIDTH];
  assign bus.out_zero  = out_zero_q;
  assign bus.out_carry = out_carry_q;
`endif

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_op_q     <= ADD;
      out_result_q <= '0;
`ifdef ALU_FLAGS_EN
      out_zero_q   <= 1'b0;
      out_carry_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            out_op_q <= bus.in_op;
            if (bus.in_op == MUL) begin
              state_q     <= MUL_BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q      <= DONE;
              out_valid_q  <= 1'b1;
              out_result_q <= alu_result;
`ifdef ALU_FLAGS_EN
              out_zero_q   <= (alu_result == '0);
              out_carry_q  <= alu_carry;
`endif
            end
          end else if (state_q == DONE && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= mul_product;
`ifdef ALU_FLAGS_EN
            out_zero_q   <= (mul_product == '0);
            out_carry_q  <= mul_carry;
`endif
          end else if (!mul_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_responder.sv
// Directed self-checking bench for alu_op_responder (WIDTH=8): vector table plus corner sequences.
module tb_alu_op_responder;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    alu_op_e     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        zero;
    logic        carry;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t vecs[12];

  alu_op_responder_if #(.WIDTH(WIDTH)) bus ();

  alu_op_responder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
  endtask

  task automatic check_flags(input string name, input logic zero, input logic carry);
`ifdef ALU_FLAGS_EN
    check({name, "_zero"}, 32'(bus.out_zero), 32'(zero));
    check({name, "_carry"}, 32'(bus.out_carry), 32'(carry));
`else
    if (zero === 1'bx || carry === 1'bx) $display("note: %s has unknown flag expectation", name);
`endif
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic busy_ok;
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(1'b1, v.op, v.a, v.b, 1'b1);
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    next_cycle();
    bus.in_valid = 1'b0;
    if (v.op == MUL) begin
      busy_ok = 1'b1;
      for (int k = 0; k < int'(WIDTH); k++) begin
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_ok = 1'b0;
        next_cycle();
      end
      check({tag, "_mul_busy"}, 32'(busy_ok), 32'd1);
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.out_result), 32'(v.res));
    check({tag, "_op"}, 32'(bus.out_op), 32'(v.op));
    check_flags(tag, v.zero, v.carry);
    next_cycle();
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic ok;
    vecs[0]  = '{ADD, 8'hFF, 8'h01, 16'h0100, 1'b0, 1'b1};
    vecs[1]  = '{ADD, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b0};
    vecs[2]  = '{ADD, 8'h80, 8'h80, 16'h0100, 1'b0, 1'b1};
    vecs[3]  = '{XOR, 8'hA5, 8'h5A, 16'h00FF, 1'b0, 1'b0};
    vecs[4]  = '{XOR, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{AND, 8'hF0, 8'h0F, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{AND, 8'hFF, 8'h3C, 16'h003C, 1'b0, 1'b0};
    vecs[7]  = '{MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1};
    vecs[8]  = '{MUL, 8'h00, 8'h37, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{MUL, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0};
    vecs[10] = '{MUL, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b1};
    vecs[11] = '{MUL, 8'h81, 8'h03, 16'h0183, 1'b0, 1'b1};

    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    #3;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.out_result), 32'd0);
    check("rst_op", 32'(bus.out_op), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_flags("rst", 1'b0, 1'b0);
    @(posedge clk);
    next_cycle();
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-to-back XOR then AND with no bubble.
    drive(1'b1, XOR, 8'hA5, 8'h5A, 1'b1);
    next_cycle();
    drive(1'b1, AND, 8'hF0, 8'h0F, 1'b1);
    #1;
    check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_first_result", 32'(bus.out_result), 32'h00FF);
    check("b2b_in_ready_done", 32'(bus.in_ready), 32'd1);
    next_cycle();
    bus.in_valid = 1'b0;
    check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_second_result", 32'(bus.out_result), 32'h0000);
    check("b2b_second_op", 32'(bus.out_op), 32'(AND));
    check_flags("b2b_second", 1'b1, 1'b0);
    next_cycle();
    check("b2b_idle", 32'(bus.out_valid), 32'd0);

    // Backpressure: result held while out_ready is low.
    drive(1'b1, ADD, 8'h03, 8'h04, 1'b0);
    next_cycle();
    bus.in_valid = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0007 || bus.in_ready !== 1'b0)
        ok = 1'b0;
      next_cycle();
    end
    check("bp_hold", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(bus.out_valid), 32'd1);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    next_cycle();
    check("bp_after_release", 32'(bus.out_valid), 32'd0);

    // MUL result consumed together with a new ADD request.
    drive(1'b1, MUL, 8'h03, 8'h05, 1'b1);
    next_cycle();
    bus.in_valid = 1'b0;
    repeat (WIDTH) next_cycle();
    check("mul_chain_result", 32'(bus.out_result), 32'h000F);
    drive(1'b1, ADD, 8'h01, 8'h01, 1'b1);
    next_cycle();
    bus.in_valid = 1'b0;
    check("mul_chain_next_valid", 32'(bus.out_valid), 32'd1);
    check("mul_chain_next_result", 32'(bus.out_result), 32'h0002);
    check("mul_chain_next_op", 32'(bus.out_op), 32'(ADD));
    next_cycle();

    // Reset in the middle of a multiply discards it.
    drive(1'b1, MUL, 8'hFF, 8'hFF, 1'b1);
    next_cycle();
    bus.in_valid = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
      next_cycle();
    end
    check("midrst_no_stale", 32'(ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
